// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector memory sequencer and related vector
// sequencers.
package vec_pkg;

    localparam int ELEM_BYTES = 4;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vec_state_e;

    // The comparison spans all 32 bits, so a large vlen clamps instead of aliasing on vlen[4:0].
    function automatic logic [CNT_W-1:0] clamp_len(input logic [31:0] vlen,
                                                   input logic [CNT_W-1:0] max_len);
        return (vlen > 32'(max_len)) ? max_len : vlen[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/vec_seq_ctrl_if.sv
// ID/EXE-side request signals and data-memory beat signals of the vector
// memory sequencer.
interface vec_seq_ctrl_if #(
    parameter int ADDR_W = 16
);
    import vec_pkg::*;

    logic              start;
    logic              op_store;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       vlen;
    logic              mem_wait;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic              stall;
    logic              busy;
    logic              done;

    modport master (
        output start, op_store, base_addr, vlen, mem_wait,
        input  cnt, mem_addr, mem_re, mem_we, stall, busy, done
    );

    modport slave (
        input  start, op_store, base_addr, vlen, mem_wait,
        output cnt, mem_addr, mem_re, mem_we, stall, busy, done
    );

endinterface

// File: rtl/vec_addr_gen.sv
// Element address generator: base + (cnt-1)*ELEM_BYTES, wrapping at ADDR_W bits.
module vec_addr_gen
    import vec_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  cnt,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] idx;

    assign idx  = ADDR_W'(cnt) - ADDR_W'(1);
    assign addr = base + (idx << $clog2(ELEM_BYTES));

endmodule

// File: rtl/vec_seq_ctrl.sv
// Vector load/store sequencer: steps the element counter through N beats and
// holds the front end stalled until the last beat retires.
module vec_seq_ctrl
    import vec_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int ADDR_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    vec_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_LEN);

    vec_state_e        state, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, n_q, n_req;
    logic [ADDR_W-1:0] base_q, base_sel, gen_addr, addr_q, addr_d;
    logic              re_q, re_d, we_q, we_d;
    logic              accept;

    assign n_req  = clamp_len(bus.vlen, MAX_N);
    assign accept = (state == IDLE) && bus.start && (n_req != '0);

    // Next-state logic; the registered outputs are computed one cycle ahead
    // so the beat address and strobes come straight from flops.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt_q;
        re_d     = re_q;
        we_d     = we_q;
        base_sel = base_q;
        case (state)
            IDLE: begin
                cnt_d    = '0;
                re_d     = 1'b0;
                we_d     = 1'b0;
                base_sel = bus.base_addr;
                if (bus.start) begin
                    if (n_req == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(1);
                        re_d    = !bus.op_store;
                        we_d    = bus.op_store;
                    end
                end
            end
            RUN: begin
                if (!bus.mem_wait) begin
                    if (cnt_q < n_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                        re_d    = 1'b0;
                        we_d    = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    vec_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .base(base_sel),
        .cnt (cnt_d),
        .addr(gen_addr)
    );

    assign addr_d = (cnt_d == '0) ? '0 : gen_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            addr_q <= '0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            re_q   <= re_d;
            we_q   <= we_d;
        end
    end

    // Operands are only read in RUN, which is always entered through accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            n_q    <= n_req;
            base_q <= bus.base_addr;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_re   = re_q;
    assign bus.mem_we   = we_q;
    assign bus.stall    = accept || (state == RUN);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed, table-driven bench for vec_seq_ctrl plus hand-written multi-cycle sequences.
module tb_vec_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vec_seq_ctrl_if #(.ADDR_W(16)) bus ();

    vec_seq_ctrl #(
        .MAX_LEN(8),
        .ADDR_W (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        op;
        logic [15:0] base;
        logic [31:0] vlen;
        logic        mwait;
        int          cnt;
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic        stall;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic void add(logic r, logic s, logic o, logic [15:0] b, logic [31:0] v,
                                logic w, int c, logic [15:0] a, logic re, logic we,
                                logic st, logic bz, logic dn);
        vec_t t;
        t.rst = r; t.start = s; t.op = o; t.base = b; t.vlen = v; t.mwait = w;
        t.cnt = c; t.addr = a; t.re = re; t.we = we; t.stall = st; t.busy = bz; t.done = dn;
        tbl.push_back(t);
    endfunction

    task automatic run_seq(input string name, input logic [15:0] base, input logic [31:0] vlen,
                           input logic op, input int exp_beats);
        int beats = 0;
        bit seen = 1'b0;
        logic [15:0] ea;
        bus.start = 1'b1; bus.op_store = op; bus.base_addr = base; bus.vlen = vlen;
        bus.mem_wait = 1'b0;
        #1 chk({name, " stall"}, 0, 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (bus.done) begin
                seen = 1'b1;
                chk({name, " done_cnt"}, k, 32'(bus.cnt), 32'd0);
            end else begin
                beats++;
                ea = base + 16'(beats - 1) * 16'd4;
                chk({name, " cnt"}, k, 32'(bus.cnt), 32'(beats));
                chk({name, " addr"}, k, 32'(bus.mem_addr), 32'(ea));
                chk({name, " re"}, k, 32'(bus.mem_re), 32'(!op));
                chk({name, " we"}, k, 32'(bus.mem_we), 32'(op));
            end
            @(negedge clk);
        end
        chk({name, " done_seen"}, 0, 32'(seen), 32'd1);
        chk({name, " beats"}, 0, 32'(beats), 32'(exp_beats));
    endtask

    initial begin
        bus.start = 1'b0; bus.op_store = 1'b0; bus.base_addr = '0; bus.vlen = '0;
        bus.mem_wait = 1'b0;

        // Reset state, then vlen=4 load at 0x0100
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        add(0,1,0,16'h0100, 4,0, 0,16'h0000,0,0,1,0,0);
        add(0,0,0,16'h0000, 0,0, 1,16'h0100,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 2,16'h0104,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 3,16'h0108,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 4,16'h010C,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,1,1);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        // vlen=20 store clamped to 8; start while busy and start in DONE are ignored
        add(0,1,1,16'h0000,20,0, 0,16'h0000,0,0,1,0,0);
        add(0,0,0,16'h0000, 0,0, 1,16'h0000,0,1,1,1,0);
        add(0,1,0,16'h5000, 2,0, 2,16'h0004,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 3,16'h0008,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 4,16'h000C,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 5,16'h0010,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 6,16'h0014,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 7,16'h0018,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 8,16'h001C,0,1,1,1,0);
        add(0,1,0,16'h0700, 4,0, 0,16'h0000,0,0,0,1,1);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        // vlen=0: no beats, done on the next cycle
        add(0,1,0,16'h0300, 0,0, 0,16'h0000,0,0,0,0,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,1,1);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        // vlen=3 load with mem_wait held for three cycles on element 2
        add(0,1,0,16'h0040, 3,0, 0,16'h0000,0,0,1,0,0);
        add(0,0,0,16'h0000, 0,0, 1,16'h0040,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,1, 2,16'h0044,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,1, 2,16'h0044,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,1, 2,16'h0044,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 2,16'h0044,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 3,16'h0048,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,1,1);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        // rst at cnt=5 of an 8-beat load, then a normal 2-beat store
        add(0,1,0,16'h0200, 8,0, 0,16'h0000,0,0,1,0,0);
        add(0,0,0,16'h0000, 0,0, 1,16'h0200,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 2,16'h0204,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 3,16'h0208,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 4,16'h020C,1,0,1,1,0);
        add(1,0,0,16'h0000, 0,0, 5,16'h0210,1,0,1,1,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);
        add(0,1,1,16'h0300, 2,0, 0,16'h0000,0,0,1,0,0);
        add(0,0,0,16'h0000, 0,0, 1,16'h0300,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 2,16'h0304,0,1,1,1,0);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,1,1);
        add(0,0,0,16'h0000, 0,0, 0,16'h0000,0,0,0,0,0);

        repeat (3) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            rst          = tbl[i].rst;
            bus.start    = tbl[i].start;
            bus.op_store = tbl[i].op;
            bus.base_addr = tbl[i].base;
            bus.vlen     = tbl[i].vlen;
            bus.mem_wait = tbl[i].mwait;
            #1;
            chk("cnt",   i, 32'(bus.cnt),      32'(tbl[i].cnt));
            chk("addr",  i, 32'(bus.mem_addr), 32'(tbl[i].addr));
            chk("re",    i, 32'(bus.mem_re),   32'(tbl[i].re));
            chk("we",    i, 32'(bus.mem_we),   32'(tbl[i].we));
            chk("stall", i, 32'(bus.stall),    32'(tbl[i].stall));
            chk("busy",  i, 32'(bus.busy),     32'(tbl[i].busy));
            chk("done",  i, 32'(bus.done),     32'(tbl[i].done));
            @(negedge clk);
        end

        rst = 1'b0;
        bus.start = 1'b0;
        bus.mem_wait = 1'b0;
        @(negedge clk);
        run_seq("wrap", 16'hFFF8, 32'd8, 1'b0, 8);
        run_seq("clamp34", 16'h1000, 32'd34, 1'b1, 8);
        run_seq("clamp_hi", 16'h2000, 32'h8000_0003, 1'b0, 8);
        run_seq("len7", 16'h3000, 32'd7, 1'b1, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
